decade_count_sequencer: RTL and testbench
=========================================

// Module: decade_count_sequencer
// PURPOSE
//  Sequences a chain of DIGITS cascaded mod-10 (BCD) digit counters: loads a preset, counts up on tick
//  strobes, and stops when the count equals a target. Supports pause/resume/abort and reports wrap-around.
//  Sits between control logic (start/stop commands, time-base tick) and the BCD display/compare path.
//  Replaces the asynchronous-clear ripple decade counter with a fully synchronous, single-clock design.
// PARAMETERS
//  DIGITS   4   number of cascaded BCD digits; count range 0 .. 10^DIGITS-1
// PORTS
//  clk      in   1          system clock; every register updates on the rising edge
//  clr      in   1          synchronous, active-low reset
//  tick     in   1          count-enable strobe; one increment per cycle in which tick=1 (RUN only)
//  start    in   1          pulse: accept preset/target and begin a count sequence
//  pause    in   1          pulse: freeze counting
//  resume   in   1          pulse: continue counting after pause
//  abort    in   1          pulse: end the sequence, return to IDLE
//  preset   in   4*DIGITS   BCD start value; digit i is bits [4i+3:4i]
//  target   in   4*DIGITS   BCD stop value; sampled together with preset on start
//  count    out  4*DIGITS   current BCD count
//  busy     out  1          1 in LOAD, RUN or PAUSE
//  done     out  1          1 while in DONE
//  wrap     out  1          1-cycle pulse when count rolls over from all-9s to all-0s
//  err      out  1          1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset (clr=0 at an edge): state=IDLE; count=0, busy=0, done=0, wrap=0, err=0; stored target=0.
//   Reset takes effect from any state, including mid-RUN.
//  Command priority in the same cycle: abort > start > pause > resume. Lower-priority commands are ignored.
//  FSM states: IDLE, LOAD, RUN, PAUSE, DONE.
//   IDLE : start with every preset and target nibble <= 9 -> LOAD; target is captured.
//          start with any nibble > 9 -> err=1 for one cycle; stay in IDLE; count unchanged.
//   LOAD : count<=preset; -> RUN. This state lasts exactly one cycle, and tick is ignored.
//   RUN  : if count==stored target -> DONE; tick is ignored in that cycle.
//          Otherwise tick=1 adds 1 to count.
//          Digit i increments only when tick=1 and digits 0..i-1 all equal 9; the carry is same-cycle.
//          A digit at 9 that increments becomes 0.
//          pause -> PAUSE. Pause takes precedence over tick in the same cycle.
//   PAUSE: count held; tick ignored; resume -> RUN.
//   DONE : count held; done=1. start is evaluated as in IDLE. abort -> IDLE.
//  abort, from any state: next state IDLE, count<=0, done=0. abort in IDLE also clears count to 0.
//  Latency: done rises on the edge after the edge on which count became equal to target.
//   preset==target gives LOAD, RUN, DONE: done rises 2 edges after the start edge.
//  Wrap-around: all-9s plus a tick gives all-0s, and wrap=1 for the cycle following that edge.
//   Counting continues, so a target below the preset is reached after the wrap.
//  start while busy: ignored. A new sequence requires DONE, IDLE or abort first.
//  Outputs are registered or decoded from state only; no combinational path from input to output.
// STRUCTURE
//  Shared package/header (bcd_pkg): FSM state encodings (3-bit), BCD_MAX=4'd9, is_bcd() nibble check.
//  Sub-module decade_digit: one 4-bit BCD digit.
//   Inputs: clk, clr, load, load_val, inc.
//   Outputs: q, tc (tc = q==9).
//  The sequencer generates DIGITS instances.
//   Each instance's inc = tick & run_ok & AND of the tc outputs of all lower digits.
//  The top level holds the FSM, the target register, the comparator, and the wrap/err pulse logic.
// TESTING
//  T1 DIGITS=4: preset=0007, target=0012, tick=1 every cycle.
//     -> count steps 0007..0012; done=1 one edge after 0012; count holds at 0012.
//  T2 preset=9998, target=0001, tick continuous.
//     -> count 9998, 9999, 0000, 0001; wrap=1 for exactly 1 cycle after 0000; then done.
//  T3 in RUN at count=0010, pause, then 5 cycles with tick=1, then resume.
//     -> count stays 0010 while paused, then increments to 0011 on the first tick after resume.
//  T4 start with preset=00A3 -> err=1 for 1 cycle; busy=0; state stays IDLE; count unchanged.
//  T5 start and abort in the same cycle in IDLE -> stays IDLE, no err.
//     Then abort in DONE at count=0012 -> IDLE, count=0000, done=0.
//  T6 clr=0 for one edge mid-RUN at count=0357 -> next cycle count=0000 and busy=done=wrap=err=0.
//     A later start behaves as it does from power-up.

Source files
------------

// File: rtl/decade_count_sequencer_pkg.sv
// Shared definitions for the decade count sequencer: FSM state encoding,
// the largest legal BCD digit value and a nibble legality check.
package decade_count_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/decade_count_sequencer_digit.sv
// One mod-10 BCD digit: synchronous load has priority over increment,
// and o_tc flags the digit sitting at 9 so higher digits can chain on it.
module decade_count_sequencer_digit
  import decade_count_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_inc,
  output logic [3:0] o_q,
  output logic       o_tc
);

  logic [3:0] r_q;

  // Digit register: clear, load, or step with 9 -> 0 roll-over.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_q <= 4'd0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_inc) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : (r_q + 4'd1);
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q  = r_q;
  assign o_tc = (r_q == BCD_MAX);

endmodule

// File: rtl/decade_count_sequencer.sv
// Sequencer for a chain of cascaded BCD digits: loads a preset, counts ticks
// until the count matches the stored target, with pause/resume/abort control.
module decade_count_sequencer
  import decade_count_sequencer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_tick,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_resume,
  input  logic                  i_abort,
  input  logic [4*DIGITS-1:0]   i_preset,
  input  logic [4*DIGITS-1:0]   i_target,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_wrap,
  output logic                  o_err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4*DIGITS-1:0]   r_target;
  logic [4*DIGITS-1:0]   r_preset;
  logic                  r_wrap;
  logic                  r_err;
  logic                  w_load;
  logic [4*DIGITS-1:0]   w_load_val;
  logic                  w_run_ok;
  logic                  w_capture;
  logic                  w_err_nxt;
  logic                  w_start_ok;
  logic                  w_match;
  logic [DIGITS-1:0]     w_tc;
  logic [DIGITS-1:0]     w_low9;
  logic                  w_all9;

  // Start is legal only when every preset and target nibble is a BCD digit.
  always_comb begin
    w_start_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_start_ok = w_start_ok & is_bcd(i_preset[4*i +: 4]) & is_bcd(i_target[4*i +: 4]);
    end
  end

  // Same-cycle carry: digit i steps only when all lower digits are at 9.
  always_comb begin
    w_low9 = {DIGITS{1'b0}};
    w_all9 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_low9[i] = w_all9;
      w_all9    = w_all9 & w_tc[i];
    end
  end

  assign w_match = (o_count == r_target);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    decade_count_sequencer_digit u_digit (
      .i_clk      (i_clk),
      .i_clr      (i_clr),
      .i_load     (w_load),
      .i_load_val (w_load_val[4*gi +: 4]),
      .i_inc      (i_tick & w_run_ok & w_low9[gi]),
      .o_q        (o_count[4*gi +: 4]),
      .o_tc       (w_tc[gi])
    );
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and digit-chain control; abort overrides, an ignored start still masks pause/resume.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = r_preset;
    w_run_ok    = 1'b0;
    w_capture   = 1'b0;
    w_err_nxt   = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b1;
      w_load_val  = {(4*DIGITS){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start && w_start_ok) begin
            w_state_nxt = ST_LOAD;
            w_capture   = 1'b1;
          end else if (i_start) begin
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_LOAD: begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_match) begin
            w_state_nxt = ST_DONE;
          end else if (i_pause && !i_start) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            w_run_ok    = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (i_resume && !i_pause && !i_start) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Preset/target capture on an accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_target <= {(4*DIGITS){1'b0}};
      r_preset <= {(4*DIGITS){1'b0}};
    end else if (w_capture) begin
      r_target <= i_target;
      r_preset <= i_preset;
    end else begin
      r_target <= r_target;
      r_preset <= r_preset;
    end
  end

  // One-cycle wrap and reject pulses.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= i_tick & w_run_ok & w_all9;
      r_err  <= w_err_nxt;
    end
  end

  assign o_wrap = r_wrap;
  assign o_err  = r_err;
  assign o_busy = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_decade_count_sequencer.sv
// Bench for decade_count_sequencer: hand-derived vector table for the directed
// scenarios, then random commands checked against an integer-valued model.
module tb_decade_count_sequencer;

  localparam int DIGITS = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        clr, tick, start, pause, resume, abort;
  logic [15:0] preset, target;
  logic [15:0] count;
  logic        busy, done, wrap, err;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_state, m_cnt, m_target, m_preset;
  logic m_wrap, m_err;

  typedef struct {
    logic        clr, tick, start, pause, resume, abort;
    logic [15:0] preset, target;
    logic [15:0] e_count;
    logic        e_busy, e_done, e_wrap, e_err;
  } vec_t;

  vec_t vecs[$];

  decade_count_sequencer #(.DIGITS(DIGITS)) dut (
    .i_clk(clk), .i_clr(clr), .i_tick(tick), .i_start(start), .i_pause(pause),
    .i_resume(resume), .i_abort(abort), .i_preset(preset), .i_target(target),
    .o_count(count), .o_busy(busy), .o_done(done), .o_wrap(wrap), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit all_bcd(input logic [15:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic vec_t mk(input logic c, input logic t, input logic s, input logic p,
                              input logic r, input logic a, input logic [15:0] pr,
                              input logic [15:0] tg, input logic [15:0] ec, input logic eb,
                              input logic ed, input logic ew, input logic ee);
    vec_t v;
    v.clr = c; v.tick = t; v.start = s; v.pause = p; v.resume = r; v.abort = a;
    v.preset = pr; v.target = tg; v.e_count = ec;
    v.e_busy = eb; v.e_done = ed; v.e_wrap = ew; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: count kept as a plain integer 0..9999.
  task automatic model_step();
    if (!clr) begin
      m_state = M_IDLE; m_cnt = 0; m_target = 0; m_preset = 0; m_wrap = 1'b0; m_err = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (abort) begin
      m_state = M_IDLE;
      m_cnt   = 0;
    end else if (m_state == M_IDLE || m_state == M_DONE) begin
      if (start && all_bcd(preset) && all_bcd(target)) begin
        m_state  = M_LOAD;
        m_preset = bcd2int(preset);
        m_target = bcd2int(target);
      end else if (start) begin
        m_err = 1'b1;
      end
    end else if (m_state == M_LOAD) begin
      m_cnt   = m_preset;
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_cnt == m_target) m_state = M_DONE;
      else if (pause && !start) m_state = M_PAUSE;
      else if (tick) begin
        if (m_cnt == 9999) m_wrap = 1'b1;
        m_cnt = (m_cnt + 1) % 10000;
      end
    end else if (m_state == M_PAUSE) begin
      if (resume && !pause && !start) m_state = M_RUN;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("count", count, int2bcd(m_cnt));
    chk("busy", {15'd0, busy}, {15'd0, (m_state == M_LOAD || m_state == M_RUN || m_state == M_PAUSE)});
    chk("done", {15'd0, done}, {15'd0, (m_state == M_DONE)});
    chk("wrap", {15'd0, wrap}, {15'd0, m_wrap});
    chk("err", {15'd0, err}, {15'd0, m_err});
  endtask

  initial begin
    int pv, tv, k;
    vec_t v;
    clr = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0; abort = 1'b0;
    preset = 16'h0000; target = 16'h0000;
    m_state = M_IDLE; m_cnt = 0; m_target = 0; m_preset = 0; m_wrap = 1'b0; m_err = 1'b0;

    //          clr tk st pa re ab preset    target    count     bsy dn wr er
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 16'h00A3, 16'h0005, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 16'h0007, 16'h0012, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 16'h0007, 16'h0012, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0009, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0011, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0012, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0012, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0012, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 16'h9998, 16'h0001, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h9998, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h9999, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 16'h0008, 16'h0050, 16'h0001, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0009, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0011, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0011, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 16'h0355, 16'h0999, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0355, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 16'h0001, 16'h0001, 16'h0356, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0357, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 16'h0357, 16'h0357, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0357, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0357, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      clr = v.clr; tick = v.tick; start = v.start; pause = v.pause;
      resume = v.resume; abort = v.abort; preset = v.preset; target = v.target;
      cycle();
      chk($sformatf("vec%0d count", i), count, v.e_count);
      chk($sformatf("vec%0d busy", i), {15'd0, busy}, {15'd0, v.e_busy});
      chk($sformatf("vec%0d done", i), {15'd0, done}, {15'd0, v.e_done});
      chk($sformatf("vec%0d wrap", i), {15'd0, wrap}, {15'd0, v.e_wrap});
      chk($sformatf("vec%0d err", i), {15'd0, err}, {15'd0, v.e_err});
    end

    for (int n = 0; n < 4000; n++) begin
      clr    = ($urandom_range(0, 511) != 0);
      tick   = 1'($urandom_range(0, 3) != 0);
      start  = ($urandom_range(0, 7) == 0);
      pause  = ($urandom_range(0, 15) == 0);
      resume = ($urandom_range(0, 7) == 0);
      abort  = ($urandom_range(0, 127) == 0);
      pv = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(9980, 9999));
      tv = (pv + int'($urandom_range(0, 40))) % 10000;
      preset = int2bcd(pv);
      target = int2bcd(tv);
      if ($urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, 3));
        preset[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      if ($urandom_range(0, 15) == 0) begin
        k = int'($urandom_range(0, 3));
        target[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
